// File: rtl/uart_rx_word.sv
// UART frame receiver (8 data bits, zero parity slot, one stop bit) that reassembles
// six-byte groups (4 payload bytes LSB-first + 0x0A 0x0D trailer) into 32-bit words.
module uart_rx_word #(
    parameter logic [9:0] BPS   = 10'd868,
    parameter logic [9:0] BPS_2 = 10'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  rx_byte,
    output logic        byte_valid,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        parity_err,
    output logic        sync_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } bit_state_t;

    typedef enum logic {
        W_ALIGNED,
        W_HUNT
    } word_state_t;

    bit_state_t  bit_state_q;
    word_state_t word_state_q;

    logic [1:0]  sync_q;
    logic        rx_d_q;
    logic        rx_s;
    logic [9:0]  cnt_q;
    logic [2:0]  bitn_q;
    logic [7:0]  shift_q;
    logic        par_q;

    logic [7:0]  rx_byte_q;
    logic        byte_valid_q;
    logic        frame_err_q;
    logic        parity_err_q;

    logic [31:0] word_q;
    logic [2:0]  idx_q;
    logic        seen0a_q;
    logic [31:0] data_out_q;
    logic        data_valid_q;
    logic        sync_err_q;

    assign rx_s = sync_q[1];

    // Bit-level deserialiser; strobes land one cycle after the stop sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '1;
            rx_d_q       <= 1'b1;
            bit_state_q  <= S_IDLE;
            cnt_q        <= '0;
            bitn_q       <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx};
            rx_d_q       <= rx_s;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            case (bit_state_q)
                S_IDLE: begin
                    if (rx_d_q && !rx_s) begin
                        bit_state_q <= S_START;
                        cnt_q       <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == BPS_2) begin
                        cnt_q       <= '0;
                        bitn_q      <= '0;
                        bit_state_q <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == BPS) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        bitn_q  <= bitn_q + 3'd1;
                        if (bitn_q == 3'd7) begin
                            bit_state_q <= S_PAR;
                        end
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                S_PAR: begin
                    if (cnt_q == BPS) begin
                        cnt_q       <= '0;
                        par_q       <= rx_s;
                        bit_state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                S_STOP: begin
                    // Return to IDLE at the stop sample so back-to-back frames are caught.
                    if (cnt_q == BPS) begin
                        cnt_q       <= '0;
                        bit_state_q <= S_IDLE;
                        if (!par_q && rx_s) begin
                            rx_byte_q    <= shift_q;
                            byte_valid_q <= 1'b1;
                        end else begin
                            frame_err_q  <= !rx_s;
                            parity_err_q <= par_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                default: bit_state_q <= S_IDLE;
            endcase
        end
    end

    // Word assembler: ALIGNED collects payload + trailer, HUNT waits for 0x0A 0x0D.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_state_q <= W_ALIGNED;
            word_q       <= '0;
            idx_q        <= '0;
            seen0a_q     <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
            if (frame_err_q || parity_err_q) begin
                word_state_q <= W_HUNT;
                idx_q        <= '0;
                seen0a_q     <= 1'b0;
            end else if (byte_valid_q) begin
                case (word_state_q)
                    W_ALIGNED: begin
                        if (idx_q < 3'd4) begin
                            word_q[{idx_q[1:0], 3'b000} +: 8] <= rx_byte_q;
                            idx_q <= idx_q + 3'd1;
                        end else if (idx_q == 3'd4 && rx_byte_q == 8'h0A) begin
                            idx_q <= 3'd5;
                        end else if (idx_q == 3'd5 && rx_byte_q == 8'h0D) begin
                            data_out_q   <= word_q;
                            data_valid_q <= 1'b1;
                            idx_q        <= '0;
                        end else begin
                            sync_err_q   <= 1'b1;
                            word_state_q <= W_HUNT;
                            idx_q        <= '0;
                            seen0a_q     <= 1'b0;
                        end
                    end
                    W_HUNT: begin
                        seen0a_q <= (rx_byte_q == 8'h0A);
                        if (rx_byte_q == 8'h0D && seen0a_q) begin
                            word_state_q <= W_ALIGNED;
                            idx_q        <= '0;
                        end
                    end
                    default: word_state_q <= W_HUNT;
                endcase
            end
        end
    end

    assign rx_byte    = rx_byte_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign sync_err   = sync_err_q;

endmodule
